slave_port_driver: RTL and testbench

- Host-side initiator for the HLS accelerator's slave memory port (S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size, responder side Sout_Rdata_ram/Sout_DataRdy) and its start_port/done_port control.
- Accepts a command stream: byte writes to preload accelerator memory, byte reads to fetch results, and start-and-wait.
- Returns one response per command, including the measured cycle count.
- Sits between the test/host harness and the top-level `main` instance, replacing the tied-off slave port.

---
 rtl/slave_port_driver.sv | 229 ++++++++++++++++++++++
 tb/tb_slave_port_driver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : slave_port_driver
// Purpose  : Host-side initiator for the accelerator slave memory port and
//            start/done handshake. Executes one command at a time (byte
//            write, byte read, start-and-wait) and returns one response.
// Revision : 1.0 - initial release
// ============================================================================
module slave_port_driver #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int MEM_TIMEOUT = 1024,
  parameter int RUN_TIMEOUT = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_data,
  output logic [31:0]           rsp_cycles,
  output logic                  rsp_err,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port
);

  localparam logic [SIZE_W-1:0] C_BYTE_SIZE = SIZE_W'(8);
  localparam logic [31:0]       C_MEM_LAST  = 32'(MEM_TIMEOUT - 1);
  localparam logic [31:0]       C_RUN_MAX   = 32'(RUN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MEM   = 3'd1,
    S_RSP   = 3'd2,
    S_START = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_cmd_ready,  w_cmd_ready_nxt;
  logic                r_oe,         w_oe_nxt;
  logic                r_we,         w_we_nxt;
  logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
  logic [7:0]          r_wdata,      w_wdata_nxt;
  logic [SIZE_W-1:0]   r_size,       w_size_nxt;
  logic                r_start,      w_start_nxt;
  logic [31:0]         r_cnt,        w_cnt_nxt;
  logic                r_rsp_valid,  w_rsp_valid_nxt;
  logic [7:0]          r_rsp_data,   w_rsp_data_nxt;
  logic [31:0]         r_rsp_cycles, w_rsp_cycles_nxt;
  logic                r_rsp_err,    w_rsp_err_nxt;
  logic [31:0]         w_cnt_inc;
  logic                w_unused;

  // Saturating increment so the run counter can never wrap
  assign w_cnt_inc = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;

  // Only channel 0 is used; upper read data and channel-1 ready are ignored
  assign w_unused = ^{Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};

  // Registered state and outputs; reset drops every output asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b0;
      r_oe         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= '0;
      r_start      <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_cycles <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_oe         <= w_oe_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_size       <= w_size_nxt;
      r_start      <= w_start_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_cycles <= w_rsp_cycles_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
    end
  end

  // Next-state and next-output decode; every register holds unless changed
  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_ready_nxt  = r_cmd_ready;
    w_oe_nxt         = r_oe;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_size_nxt       = r_size;
    w_start_nxt      = r_start;
    w_cnt_nxt        = r_cnt;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_cycles_nxt = r_rsp_cycles;
    w_rsp_err_nxt    = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready_nxt = 1'b0;
          w_cnt_nxt       = '0;
          case (cmd_op)
            2'b00: begin
              w_state_nxt = S_MEM;
              w_we_nxt    = 1'b1;
              w_addr_nxt  = cmd_addr;
              w_wdata_nxt = cmd_wdata;
              w_size_nxt  = C_BYTE_SIZE;
            end
            2'b01: begin
              w_state_nxt = S_MEM;
              w_oe_nxt    = 1'b1;
              w_addr_nxt  = cmd_addr;
              w_wdata_nxt = '0;
              w_size_nxt  = C_BYTE_SIZE;
            end
            2'b10: begin
              w_state_nxt = S_START;
              w_start_nxt = 1'b1;
            end
            default: begin
              w_state_nxt      = S_RSP;
              w_rsp_valid_nxt  = 1'b1;
              w_rsp_data_nxt   = '0;
              w_rsp_cycles_nxt = '0;
              w_rsp_err_nxt    = 1'b1;
            end
          endcase
        end
      end

      S_MEM: begin
        if (Sout_DataRdy[0] || (r_cnt == C_MEM_LAST)) begin
          // Completion or timeout: retire the request and report
          w_state_nxt      = S_RSP;
          w_oe_nxt         = 1'b0;
          w_we_nxt         = 1'b0;
          w_addr_nxt       = '0;
          w_wdata_nxt      = '0;
          w_size_nxt       = '0;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_cycles_nxt = '0;
          w_rsp_err_nxt    = ~Sout_DataRdy[0];
          w_rsp_data_nxt   = (Sout_DataRdy[0] && r_oe) ? Sout_Rdata_ram[7:0] : 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end

      S_START: begin
        // done_port here is left over from a previous run and is ignored
        w_start_nxt = 1'b0;
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        if (done_port) begin
          w_state_nxt      = S_RSP;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_data_nxt   = '0;
          w_rsp_cycles_nxt = w_cnt_inc;
          w_rsp_err_nxt    = 1'b0;
        end else if (w_cnt_inc >= C_RUN_MAX) begin
          w_state_nxt      = S_RSP;
          w_rsp_valid_nxt  = 1'b1;
          w_rsp_data_nxt   = '0;
          w_rsp_cycles_nxt = C_RUN_MAX;
          w_rsp_err_nxt    = 1'b1;
        end
      end

      S_RSP: begin
        if (rsp_ready) begin
          w_state_nxt      = S_IDLE;
          w_cmd_ready_nxt  = 1'b1;
          w_rsp_valid_nxt  = 1'b0;
          w_rsp_data_nxt   = '0;
          w_rsp_cycles_nxt = '0;
          w_rsp_err_nxt    = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready       = r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign rsp_cycles      = r_rsp_cycles;
  assign rsp_err         = r_rsp_err;
  assign start_port      = r_start;
  assign S_oe_ram        = {1'b0, r_oe};
  assign S_we_ram        = {1'b0, r_we};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, r_addr};
  assign S_Wdata_ram     = {{(2*DATA_W-8){1'b0}}, r_wdata};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, r_size};

endmodule
`default_nettype wire

// File: tb/tb_slave_port_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_port_driver
// Purpose  : Self-checking bench: command driver with expected-response
//            queue, memory responder model, and response monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_port_driver;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;
  localparam int MEM_TO = 16;
  localparam int RUN_TO = 64;
  localparam logic [209:0] IDLE_PAT = {1'b1, 209'd0};

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = '0;
  logic [ADDR_W-1:0]    cmd_addr = '0;
  logic [7:0]           cmd_wdata = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [7:0]           rsp_data;
  logic [31:0]          rsp_cycles;
  logic                 rsp_err;
  logic [1:0]           S_oe_ram, S_we_ram;
  logic [2*ADDR_W-1:0]  S_addr_ram;
  logic [2*DATA_W-1:0]  S_Wdata_ram;
  logic [2*SIZE_W-1:0]  S_data_ram_size;
  logic [2*DATA_W-1:0]  Sout_Rdata_ram = '0;
  logic [1:0]           Sout_DataRdy = '0;
  logic                 start_port;
  logic                 done_port = 1'b0;
  logic [209:0]         w_all;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] cycles;
    logic        err;
    int          hold;   // -1: random rsp_ready, else low for this many cycles
  } exp_t;
  exp_t q[$];

  logic [7:0] model_mem [0:1023];
  logic [7:0] resp_mem  [0:1023];

  // Responder knobs for the command currently in flight
  logic [1:0]        cur_op = '0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [7:0]        cur_wdata = '0;
  int                mem_delay = 1;
  bit                mem_hang = 1'b0;
  int                exp_vis = 1;

  slave_port_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .MEM_TIMEOUT(MEM_TO), .RUN_TIMEOUT(RUN_TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_cycles(rsp_cycles), .rsp_err(rsp_err),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port)
  );

  assign w_all = {cmd_ready, rsp_valid, rsp_data, rsp_cycles, rsp_err, S_oe_ram,
                  S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port};

  initial forever #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: checks the request bus and answers after mem_delay cycles
  initial begin : responder
    int vis;
    logic [1:0] eoe, ewe;
    logic [7:0] ewd;
    vis = 0;
    forever begin
      @(negedge clock);
      Sout_DataRdy[1] = 1'($urandom_range(0, 1));
      Sout_Rdata_ram  = {$urandom, $urandom, $urandom, $urandom};
      if (reset) begin
        vis = 0;
        Sout_DataRdy[0] = 1'b0;
        continue;
      end
      if (S_oe_ram[0] || S_we_ram[0]) begin
        vis++;
        eoe = (cur_op == 2'b01) ? 2'b01 : 2'b00;
        ewe = (cur_op == 2'b00) ? 2'b01 : 2'b00;
        ewd = (cur_op == 2'b00) ? cur_wdata : 8'd0;
        check("req_fields", {S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, S_Wdata_ram},
              {eoe, ewe, {ADDR_W{1'b0}}, cur_addr, {SIZE_W{1'b0}}, 7'd8, 120'd0, ewd});
        if (!mem_hang && vis == mem_delay) begin
          Sout_DataRdy[0] = 1'b1;
          if (S_we_ram[0]) resp_mem[S_addr_ram[ADDR_W-1:0]] = S_Wdata_ram[7:0];
          Sout_Rdata_ram[7:0] = resp_mem[S_addr_ram[ADDR_W-1:0]];
        end else begin
          Sout_DataRdy[0] = 1'b0;
        end
      end else begin
        if (vis != 0) check("req_length", 256'(vis), 256'(exp_vis));
        vis = 0;
        check("bus_idle", {S_oe_ram, S_we_ram, S_addr_ram, S_data_ram_size, S_Wdata_ram}, '0);
        Sout_DataRdy[0] = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response monitor: pops the expected queue on each new response
  initial begin : monitor
    bit pending;
    int hold_left;
    exp_t e;
    logic [40:0] held;
    pending = 1'b0;
    hold_left = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pending = 1'b0;
        rsp_ready = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (!pending) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got data=%0h cycles=%0d err=%0b required no response",
                     rsp_data, rsp_cycles, rsp_err);
            e.data = rsp_data; e.cycles = rsp_cycles; e.err = rsp_err; e.hold = 0;
          end else begin
            e = q.pop_front();
            check("rsp_fields", {rsp_data, rsp_cycles, rsp_err}, {e.data, e.cycles, e.err});
          end
          held = {rsp_data, rsp_cycles, rsp_err};
          hold_left = (e.hold > 0) ? e.hold : 0;
          pending = 1'b1;
        end else begin
          check("rsp_stable", {rsp_data, rsp_cycles, rsp_err}, held);
        end
        check("cmd_ready_while_rsp", cmd_ready, 1'b0);
        if (hold_left > 0) begin
          rsp_ready = 1'b0;
          hold_left--;
        end else if (e.hold < 0) begin
          rsp_ready = 1'($urandom_range(0, 1));
        end else begin
          rsp_ready = 1'b1;
        end
        if (rsp_ready) pending = 1'b0;
      end else begin
        check("rsp_idle", {rsp_data, rsp_cycles, rsp_err}, '0);
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Issue one command; k is the run length for start (0 = never signal done)
  task automatic do_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [7:0] wd, input int dly, input bit hang,
                        input int k, input int hold, input bit push);
    exp_t e;
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!cmd_ready && n < 500);
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0 required 1 within 500 cycles");
      return;
    end
    cur_op = op; cur_addr = addr; cur_wdata = wd;
    mem_delay = dly; mem_hang = hang;
    exp_vis = hang ? MEM_TO : dly;
    e.data = 8'd0; e.cycles = 32'd0; e.err = 1'b0; e.hold = hold;
    case (op)
      2'b00: if (!hang) model_mem[addr] = wd; else e.err = 1'b1;
      2'b01: if (!hang) e.data = model_mem[addr]; else e.err = 1'b1;
      2'b10: begin
        e.cycles = (k == 0) ? 32'(RUN_TO) : 32'(k);
        e.err = (k == 0);
      end
      default: e.err = 1'b1;
    endcase
    if (push) q.push_back(e);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    last_accept = cyc;
    cmd_op = 2'($urandom); cmd_addr = ADDR_W'($urandom); cmd_wdata = 8'($urandom);
    check("cmd_ready_drop", cmd_ready, 1'b0);
    if (op == 2'b10) begin
      check("start_rise", start_port, 1'b1);
      @(negedge clock);
      done_port = 1'b1;        // stale done during the start cycle
      @(posedge clock);
      #1;
      done_port = 1'b0;
      check("start_fall", start_port, 1'b0);
      if (k > 0) begin
        repeat (k - 1) @(posedge clock);
        #1 done_port = 1'b1;
        @(posedge clock);
        #1 done_port = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset(input string name);
    #2 reset = 1'b1;
    #1 check(name, w_all, '0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    check("rst_release_cmd_ready", cmd_ready, 1'b0);
    @(negedge clock);
    check("post_rst_idle", w_all, IDLE_PAT);
  endtask

  initial begin : main
    int a1, n, mism;
    int r, k, hold;
    logic [ADDR_W-1:0] ad;
    for (int i = 0; i < 1024; i++) begin
      model_mem[i] = 8'($urandom);
      resp_mem[i]  = model_mem[i];
    end

    // Reset state and release
    repeat (3) @(negedge clock);
    check("rst_outs", w_all, '0);
    #2 reset = 1'b0;
    check("rst_release_cmd_ready", cmd_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_outs", w_all, IDLE_PAT);
    end

    // Directed cases
    do_cmd(2'b00, 10'h2A, 8'hC3, 2, 1'b0, 0, -1, 1'b1);
    do_cmd(2'b01, 10'h2A, 8'h00, 1, 1'b0, 0, 3, 1'b1);
    do_cmd(2'b10, 10'h0, 8'h00, 1, 1'b0, 37, -1, 1'b1);
    do_cmd(2'b01, 10'h05, 8'h00, 1, 1'b1, 0, -1, 1'b1);
    do_cmd(2'b11, 10'h3FF, 8'hFF, 1, 1'b0, 0, 0, 1'b1);
    do_cmd(2'b10, 10'h0, 8'h00, 1, 1'b0, 0, -1, 1'b1);
    do_cmd(2'b10, 10'h0, 8'h00, 1, 1'b0, 1, -1, 1'b1);
    do_cmd(2'b10, 10'h0, 8'h00, 1, 1'b0, RUN_TO - 1, -1, 1'b1);

    // Back-to-back writes with immediate ready: throughput bound
    do_cmd(2'b00, 10'h01, 8'h11, 1, 1'b0, 0, 0, 1'b1);
    a1 = last_accept;
    do_cmd(2'b00, 10'h02, 8'h22, 1, 1'b0, 0, 0, 1'b1);
    check("throughput_le4", 256'(last_accept - a1 <= 4), 256'(1));

    // Abort while running and while a memory request is pending
    do_cmd(2'b10, 10'h0, 8'h00, 1, 1'b0, 0, -1, 1'b0);
    repeat (5) @(negedge clock);
    pulse_reset("rst_in_run");
    do_cmd(2'b01, 10'h07, 8'h00, 1, 1'b1, 0, -1, 1'b0);
    repeat (4) @(negedge clock);
    check("req_before_rst", S_oe_ram, 2'b01);
    pulse_reset("rst_in_mem");
    do_cmd(2'b00, 10'h2A, 8'h5A, 1, 1'b0, 0, -1, 1'b1);
    do_cmd(2'b01, 10'h2A, 8'h00, 3, 1'b0, 0, -1, 1'b1);

    // Randomized command stream
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      ad = ADDR_W'($urandom_range(0, 15));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      if (r < 40)      do_cmd(2'b00, ad, 8'($urandom), $urandom_range(1, 4), 1'b0, 0, hold, 1'b1);
      else if (r < 80) do_cmd(2'b01, ad, 8'($urandom), $urandom_range(1, 4), 1'b0, 0, hold, 1'b1);
      else if (r < 84) do_cmd(2'b01, ad, 8'h00, 1, 1'b1, 0, hold, 1'b1);
      else if (r < 93) begin
        k = $urandom_range(1, 40);
        do_cmd(2'b10, ad, 8'h00, 1, 1'b0, k, hold, 1'b1);
      end
      else if (r < 95) do_cmd(2'b10, ad, 8'h00, 1, 1'b0, 0, hold, 1'b1);
      else             do_cmd(2'b11, ad, 8'($urandom), 1, 1'b0, 0, hold, 1'b1);
    end

    // Drain outstanding responses
    n = 0;
    while ((q.size() != 0 || rsp_valid || !cmd_ready) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue_empty", 256'(q.size()), '0);
    mism = 0;
    for (int i = 0; i < 1024; i++) if (resp_mem[i] !== model_mem[i]) mism++;
    check("mem_contents", 256'(mism), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
